fpu_mul_issue: RTL and testbench

- Issue/retire sequencer sitting directly upstream and downstream of the FP16 multiply coprocessor.
- Accepts operand pairs on a valid/ready interface and holds them stable on the coprocessor inputs.
- Clears and starts the coprocessor, waits for its done, then registers the result and condition codes onto a valid/ready output.
- Exists because the coprocessor FSM parks in its done state until reset; this block re-arms it for every operation.

---
 rtl/fpu_mul_issue.sv | 90 +++++++++
 tb/tb_fpu_mul_issue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mul_issue.sv
// fpu_mul_issue: issue/retire sequencer that re-arms the FP16 multiply coprocessor for every operation
// Ports: clock, reset (sync, active-high); in_valid/in_ready/in_a/in_b operand intake;
//        mul_in1/mul_in2/mul_start/mul_reset/mul_out/mul_done/mul_cond coprocessor side;
//        out_valid/out_ready/out_result/out_cond/out_timeout registered result side.
// Optional FPU_MUL_ISSUE_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES with qNaN, V set, out_timeout=1.
module fpu_mul_issue #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMO_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mul_in1,
  output logic [15:0] mul_in2,
  output logic        mul_start,
  output logic        mul_reset,
  input  logic [15:0] mul_out,
  input  logic        mul_done,
  input  logic [3:0]  mul_cond,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_cond,
  output logic        out_timeout
);
  typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, OUT} state_t;
  state_t state, nextState;
  logic tmoHit;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || TMO_W < 2) begin : g_badParam
    $error("fpu_mul_issue: TIMEOUT_CYCLES out of range 2..65535");
  end
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
  logic [TMO_W-1:0] tmoCnt;
  logic timeoutReg;
  assign tmoHit = tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1);
  assign out_timeout = timeoutReg;
  always_ff @(posedge clock) begin
    if (reset) tmoCnt <= '0;
    else if (state == START) tmoCnt <= '0;
    else if (state == WAIT && !mul_done) tmoCnt <= tmoCnt + TMO_W'(tmoCnt != '1);
  end
  // A done arriving on the limit cycle takes the normal capture path.
  always_ff @(posedge clock) begin
    if (reset) timeoutReg <= 1'b0;
    else if (state == WAIT && (mul_done || tmoHit)) timeoutReg <= !mul_done;
  end
`else
  assign tmoHit = 1'b0;
  assign out_timeout = 1'b0;
`endif
  assign mul_reset = reset || state == CLEAR;
  assign mul_start = state == START;
  assign in_ready = state == IDLE;
  assign out_valid = state == OUT;
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  always_comb begin
    nextState = state;
    case (state)
      IDLE:  nextState = in_valid ? CLEAR : IDLE;
      CLEAR: nextState = START;
      START: nextState = WAIT;
      WAIT:  nextState = (mul_done || tmoHit) ? OUT : WAIT;
      OUT:   nextState = out_ready ? IDLE : OUT;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mul_in1 <= '0;
      mul_in2 <= '0;
      out_result <= '0;
      out_cond <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        mul_in1 <= in_a;
        mul_in2 <= in_b;
      end
      if (state == WAIT && (mul_done || tmoHit)) begin
        out_result <= mul_done ? mul_out : 16'h7E00;
        out_cond <= mul_done ? mul_cond : 4'b0001;
      end
    end
  end
endmodule

// File: tb/tb_fpu_mul_issue.sv
// tb_fpu_mul_issue: directed self-checking bench for fpu_mul_issue with a parked-done coprocessor stub
module tb_fpu_mul_issue;
  logic clock = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic [15:0] in_a = 0, in_b = 0, mul_in1, mul_in2, mul_out, out_result;
  logic in_ready, mul_start, mul_reset, mul_done, out_valid, out_timeout;
  logic [3:0] mul_cond, out_cond;
  logic [15:0] stubOut = 0;
  logic [3:0] stubCond = 0;
  logic stubDone = 0, stubBusy = 0, stubEn = 1;
  int stubLat = 0, stubCnt = 0;
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  fpu_mul_issue #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_start(mul_start), .mul_reset(mul_reset), .mul_out(mul_out),
    .mul_done(mul_done), .mul_cond(mul_cond), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_cond(out_cond),
    .out_timeout(out_timeout)
  );
  // Coprocessor stub: done rises stubLat+1 edges after start is seen and parks high until mul_reset.
  assign mul_done = stubDone;
  assign mul_out = stubDone ? stubOut : 16'hDEAD;
  assign mul_cond = stubDone ? stubCond : 4'hF;
  always @(posedge clock) begin
    if (mul_reset) begin
      stubDone <= 0;
      stubBusy <= 0;
    end else if (mul_start) begin
      stubBusy <= 1;
      stubCnt <= 0;
    end else if (stubBusy && stubEn) begin
      if (stubCnt == stubLat) begin
        stubDone <= 1;
        stubBusy <= 0;
      end else stubCnt <= stubCnt + 1;
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1;
    step();
    step();
    total++;
    if (mul_reset !== 1 || out_valid !== 0 || out_result !== 0 || out_cond !== 0 || mul_in1 !== 0 || mul_in2 !== 0 || out_timeout !== 0) begin
      bad++;
      $display("FAIL reset_hold: mul_reset=%b out_valid=%b out_result=%h out_cond=%h mul_in1=%h mul_in2=%h tmo=%b, required 1 0 0000 0 0000 0000 0",
               mul_reset, out_valid, out_result, out_cond, mul_in1, mul_in2, out_timeout);
    end
    reset = 0;
    #1;
    total++;
    if (mul_reset !== 0 || in_ready !== 1 || mul_start !== 0) begin
      bad++;
      $display("FAIL reset_release: mul_reset=%b in_ready=%b mul_start=%b, required 0 1 0", mul_reset, in_ready, mul_start);
    end
  endtask
  // One full operation; lat is the stub delay, so the DUT spends lat+2 cycles in WAIT.
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] res,
                       input logic [3:0] cond, input int lat, input int stall, input string tag);
    int n, rs, st;
    bit moved;
    stubOut = res;
    stubCond = cond;
    stubLat = lat;
    stubEn = 1;
    in_a = a;
    in_b = b;
    in_valid = 1;
    total++;
    if (in_ready !== 1) begin
      bad++;
      $display("FAIL %s_accept: in_ready=%b, required 1", tag, in_ready);
    end
    step();
    in_valid = 0;
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    total++;
    if (mul_reset !== 1 || mul_start !== 0 || in_ready !== 0 || mul_in1 !== a || mul_in2 !== b) begin
      bad++;
      $display("FAIL %s_clear: mul_reset=%b mul_start=%b in_ready=%b mul_in1=%h mul_in2=%h, required 1 0 0 %h %h",
               tag, mul_reset, mul_start, in_ready, mul_in1, mul_in2, a, b);
    end
    step();
    total++;
    if (mul_start !== 1 || mul_reset !== 0) begin
      bad++;
      $display("FAIL %s_start: mul_start=%b mul_reset=%b, required 1 0", tag, mul_start, mul_reset);
    end
    n = 0;
    rs = 0;
    st = 0;
    moved = 0;
    step();
    while (!out_valid && n < 100) begin
      n++;
      rs += int'(mul_reset);
      st += int'(mul_start);
      if (mul_in1 !== a || mul_in2 !== b) moved = 1;
      step();
    end
    total++;
    if (n != lat + 2 || rs != 0 || st != 0 || moved) begin
      bad++;
      $display("FAIL %s_wait: wait_cycles=%0d extra_resets=%0d extra_starts=%0d operand_moved=%b, required %0d 0 0 0",
               tag, n, rs, st, moved, lat + 2);
    end
    total++;
    if (out_valid !== 1 || out_result !== res || out_cond !== cond || out_timeout !== 0) begin
      bad++;
      $display("FAIL %s_result: valid=%b result=%h cond=%b tmo=%b, required 1 %h %b 0",
               tag, out_valid, out_result, out_cond, out_timeout, res, cond);
    end
    out_ready = 0;
    for (int i = 0; i < stall; i++) begin
      step();
      total++;
      if (out_valid !== 1 || out_result !== res || out_cond !== cond || in_ready !== 0) begin
        bad++;
        $display("FAIL %s_stall%0d: valid=%b result=%h cond=%b in_ready=%b, required 1 %h %b 0",
                 tag, i, out_valid, out_result, out_cond, in_ready, res, cond);
      end
    end
    out_ready = 1;
    step();
    out_ready = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++;
      $display("FAIL %s_retire: out_valid=%b in_ready=%b, required 0 1", tag, out_valid, in_ready);
    end
  endtask
  task automatic test_basic();
    runOp(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 0, 0, "basic");
  endtask
  task automatic test_negative();
    runOp(16'hC000, 16'h4200, 16'hC600, 4'b0010, 1, 0, "negative");
  endtask
  task automatic test_zero();
    runOp(16'h0000, 16'h3C00, 16'h0000, 4'b1000, 3, 0, "zero");
  endtask
  task automatic test_back_to_back();
    runOp(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 2, 10, "b2b_first");
    runOp(16'h4200, 16'h4200, 16'h4880, 4'b0000, 0, 0, "b2b_second");
  endtask
  // Done lands on the 8th WAIT cycle, i.e. the same cycle as the timeout limit.
  task automatic test_done_at_limit();
    runOp(16'h4000, 16'h4000, 16'h4400, 4'b0000, 6, 0, "limit");
  endtask
  task automatic test_reset_mid_wait();
    stubEn = 0;
    in_a = 16'h3C00;
    in_b = 16'h4000;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    step();
    reset = 1;
    #1;
    total++;
    if (mul_reset !== 1 || in_ready !== 0 || out_valid !== 0) begin
      bad++;
      $display("FAIL midwait_during: mul_reset=%b in_ready=%b out_valid=%b, required 1 0 0", mul_reset, in_ready, out_valid);
    end
    step();
    reset = 0;
    #1;
    total++;
    if (in_ready !== 1 || out_valid !== 0 || out_result !== 0 || out_cond !== 0 || mul_in1 !== 0 || mul_in2 !== 0 || mul_reset !== 0) begin
      bad++;
      $display("FAIL midwait_after: in_ready=%b out_valid=%b out_result=%h out_cond=%b mul_in1=%h mul_in2=%h mul_reset=%b, required 1 0 0000 0000 0000 0000 0",
               in_ready, out_valid, out_result, out_cond, mul_in1, mul_in2, mul_reset);
    end
    stubEn = 1;
  endtask
  task automatic test_timeout();
    int n;
    stubEn = 0;
    in_a = 16'h3C00;
    in_b = 16'h3C00;
    in_valid = 1;
    step();
    in_valid = 0;
    step();
    step();
    n = 0;
    step();
    while (!out_valid && n < 1000) begin
      n++;
      step();
    end
`ifdef FPU_MUL_ISSUE_TIMEOUT_EN
    total++;
    if (n != 8 || out_result !== 16'h7E00 || out_cond !== 4'b0001 || out_timeout !== 1) begin
      bad++;
      $display("FAIL timeout_abort: wait_cycles=%0d result=%h cond=%b tmo=%b, required 8 7e00 0001 1",
               n, out_result, out_cond, out_timeout);
    end
    out_ready = 1;
    step();
    out_ready = 0;
    total++;
    if (out_valid !== 0 || in_ready !== 1) begin
      bad++;
      $display("FAIL timeout_retire: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
`else
    total++;
    if (n != 1000 || out_valid !== 0 || out_timeout !== 0) begin
      bad++;
      $display("FAIL timeout_none: wait_cycles=%0d out_valid=%b tmo=%b, required 1000 0 0", n, out_valid, out_timeout);
    end
    reset = 1;
    step();
    reset = 0;
    #1;
    total++;
    if (in_ready !== 1 || out_valid !== 0) begin
      bad++;
      $display("FAIL timeout_recover: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
`endif
    stubEn = 1;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_back_to_back();
    test_done_at_limit();
    test_reset_mid_wait();
    test_timeout();
    runOp(16'h3E00, 16'h4000, 16'h4200, 4'b0000, 0, 0, "post");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
